// File: rtl/mul_share_pkg.sv
// mul_share_pkg
// Shared definitions for the multiplier-sharing controller: controller
// state encoding, operand/product widths and the default watchdog limit.
package mul_share_pkg;

  localparam int OP_W        = 32;
  localparam int PROD_W      = 64;
  localparam int DEF_TIMEOUT = 40;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/mul_share_rr_pick.sv
// rr_pick
// Combinational round-robin priority select. Starting at ptr_i and wrapping
// upward, the first set request bit wins.
// Ports:
//   req_i  [N]   request vector
//   ptr_i  [PW]  index holding highest priority
//   gnt_o  [N]   one-hot winner (all zero when no request)
//   any_o        at least one request present
module rr_pick
  import mul_share_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          any_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl
// Round-robin controller sharing one sequential 32x32 multiplier between N
// requesters. It latches the winning request's operands, pulses the
// multiplier restart, waits for the valid strobe and hands the 64-bit
// product back to the owner.
// Optional feature: define MUL_SHARE_TIMEOUT_EN to enable a WAIT watchdog
// that aborts after TIMEOUT cycles with product=0 and err_o=1.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i [N]              per-requester request level
//   a_i, b_i [32*N]        operands, slice i for requester i
//   sign_i [N]             signed-mode bit per requester
//   gnt_o [N]              one-hot grant pulse (operands latched this cycle)
//   done_o [N]             one-hot completion pulse
//   product_o [64]         result, held until the next done
//   err_o                  watchdog abort flag, pulses with done
//   mul_a_o, mul_b_o [32]  operands to the multiplier
//   mul_sign_o             sign mode to the multiplier
//   mul_start_o            one-cycle restart pulse to the multiplier
//   mul_product_i [64]     multiplier result
//   mul_valid_i            multiplier completion strobe
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        req_i,
  input  logic [OP_W*N-1:0]   a_i,
  input  logic [OP_W*N-1:0]   b_i,
  input  logic [N-1:0]        sign_i,
  output logic [N-1:0]        gnt_o,
  output logic [N-1:0]        done_o,
  output logic [PROD_W-1:0]   product_o,
  output logic                err_o,
  output logic [OP_W-1:0]     mul_a_o,
  output logic [OP_W-1:0]     mul_b_o,
  output logic                mul_sign_o,
  output logic                mul_start_o,
  input  logic [PROD_W-1:0]   mul_product_i,
  input  logic                mul_valid_i
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [OP_W-1:0]     mul_a_q, mul_a_d;
  logic [OP_W-1:0]     mul_b_q, mul_b_d;
  logic                mul_sign_q, mul_sign_d;
  logic [PROD_W-1:0]   product_q, product_d;

`ifdef MUL_SHARE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  logic [N-1:0]        pick_gnt;
  logic                pick_any;
  logic [PW-1:0]       pick_idx;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // One-hot winner converted to an index for owner bookkeeping and slicing.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  // Next-state and Mealy outputs. All outputs are forced low during a reset
  // cycle so an aborted transaction never produces a stray gnt/done.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_sign_d  = mul_sign_q;
    product_d   = product_q;
    gnt_o       = '0;
    done_o      = '0;
    err_o       = 1'b0;
    mul_start_o = 1'b0;
`ifdef MUL_SHARE_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_o      = pick_gnt;
            owner_d    = pick_idx;
            mul_a_d    = a_i[int'(pick_idx)*OP_W +: OP_W];
            mul_b_d    = b_i[int'(pick_idx)*OP_W +: OP_W];
            mul_sign_d = sign_i[pick_idx];
            state_d    = LAUNCH;
          end
        end
        LAUNCH: begin
          mul_start_o = 1'b1;
          state_d     = WAIT;
`ifdef MUL_SHARE_TIMEOUT_EN
          cnt_d       = '0;
          err_d       = 1'b0;
`endif
        end
        WAIT: begin
          // A valid strobe in the same cycle as the timeout takes priority.
          if (mul_valid_i) begin
            product_d = mul_product_i;
            state_d   = DONE;
`ifdef MUL_SHARE_TIMEOUT_EN
            err_d     = 1'b0;
          end else if (cnt_q == CW'(TIMEOUT)) begin
            product_d = '0;
            err_d     = 1'b1;
            state_d   = DONE;
          end else begin
            cnt_d     = cnt_q + CW'(1);
`endif
          end
        end
        DONE: begin
          done_o[owner_q] = 1'b1;
`ifdef MUL_SHARE_TIMEOUT_EN
          err_o           = err_q;
`endif
          if (int'(owner_q) == N - 1) ptr_d = '0;
          else                        ptr_d = owner_q + PW'(1);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sign_q <= 1'b0;
      product_q  <= '0;
`ifdef MUL_SHARE_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_sign_q <= mul_sign_d;
      product_q  <= product_d;
`ifdef MUL_SHARE_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign mul_a_o    = mul_a_q;
  assign mul_b_o    = mul_b_q;
  assign mul_sign_o = mul_sign_q;
  assign product_o  = product_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb_mul_share_ctrl
// Directed bench for mul_share_ctrl with N=2. The bench plays the role of
// the multiplier, answering each restart with a product it computes from
// the operands it supplied. Expected results are queued at grant time and
// popped when done is observed.
module tb_mul_share_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    req_i;
  logic [63:0]   a_i;
  logic [63:0]   b_i;
  logic [1:0]    sign_i;
  logic [1:0]    gnt_o;
  logic [1:0]    done_o;
  logic [63:0]   product_o;
  logic          err_o;
  logic [31:0]   mul_a_o;
  logic [31:0]   mul_b_o;
  logic          mul_sign_o;
  logic          mul_start_o;
  logic [63:0]   mul_product_i;
  logic          mul_valid_i;

  always #5 clk_i = ~clk_i;

  mul_share_ctrl #(.N(2), .TIMEOUT(40)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .sign_i        (sign_i),
    .gnt_o         (gnt_o),
    .done_o        (done_o),
    .product_o     (product_o),
    .err_o         (err_o),
    .mul_a_o       (mul_a_o),
    .mul_b_o       (mul_b_o),
    .mul_sign_o    (mul_sign_o),
    .mul_start_o   (mul_start_o),
    .mul_product_i (mul_product_i),
    .mul_valid_i   (mul_valid_i)
  );

  typedef struct {
    int          owner;
    logic [63:0] prod;
  } exp_t;

  exp_t        expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] opA[2];
  logic [31:0] opB[2];
  logic        opS[2];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setOps(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s);
    opA[idx] = a;
    opB[idx] = b;
    opS[idx] = s;
    a_i[idx*32 +: 32] = a;
    b_i[idx*32 +: 32] = b;
    sign_i[idx] = s;
  endtask

  function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".gnt"},      64'(gnt_o),       64'd0);
    checkOutput({tag, ".done"},     64'(done_o),      64'd0);
    checkOutput({tag, ".err"},      64'(err_o),       64'd0);
    checkOutput({tag, ".start"},    64'(mul_start_o), 64'd0);
    checkOutput({tag, ".product"},  product_o,        64'd0);
    checkOutput({tag, ".mul_a"},    64'(mul_a_o),     64'd0);
    checkOutput({tag, ".mul_b"},    64'(mul_b_o),     64'd0);
    checkOutput({tag, ".mul_sign"}, 64'(mul_sign_o),  64'd0);
  endtask

  // One full transaction starting at a mid-cycle point in IDLE. waitCycles
  // is the number of WAIT cycles with mul_valid low before the valid cycle.
  task automatic applyStimulus(input string tag, input logic [1:0] reqs, input int owner,
                               input int waitCycles, input logic holdReq, input logic [63:0] expProd);
    exp_t        e;
    exp_t        got;
    logic [1:0]  oh;
    oh = 2'b01 << owner;
    req_i = reqs;
    e.owner = owner;
    e.prod  = expProd;
    expQ.push_back(e);
    #1;
    checkOutput({tag, ".gnt"}, 64'(gnt_o), 64'(oh));
    @(negedge clk_i);
    if (!holdReq) req_i[owner] = 1'b0;
    checkOutput({tag, ".start"},    64'(mul_start_o), 64'd1);
    checkOutput({tag, ".gnt_off"},  64'(gnt_o),       64'd0);
    checkOutput({tag, ".mul_a"},    64'(mul_a_o),     64'(opA[owner]));
    checkOutput({tag, ".mul_b"},    64'(mul_b_o),     64'(opB[owner]));
    checkOutput({tag, ".mul_sign"}, 64'(mul_sign_o),  64'(opS[owner]));
    for (int k = 0; k < waitCycles; k++) begin
      @(negedge clk_i);
      checkOutput({tag, ".wait_done"}, 64'(done_o), 64'd0);
    end
    @(negedge clk_i);
    mul_valid_i   = 1'b1;
    mul_product_i = mulModel(opA[owner], opB[owner], opS[owner]);
    @(negedge clk_i);
    mul_valid_i   = 1'b0;
    mul_product_i = ~mul_product_i;
    got = expQ.pop_front();
    oh  = 2'b01 << got.owner;
    checkOutput({tag, ".done"},     64'(done_o), 64'(oh));
    checkOutput({tag, ".product"},  product_o,   got.prod);
    checkOutput({tag, ".err"},      64'(err_o),  64'd0);
    checkOutput({tag, ".gnt_done"}, 64'(gnt_o),  64'd0);
    if (!holdReq) req_i = 2'b00;
    @(negedge clk_i);
    checkOutput({tag, ".held"},     product_o,   got.prod);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    rst_i = 1'b1;
    req_i = 2'b00;
    a_i = '0;
    b_i = '0;
    sign_i = 2'b00;
    mul_product_i = '0;
    mul_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkAllZero("reset");
    rst_i = 1'b0;

    // Stray valid while idle must do nothing.
    @(negedge clk_i);
    mul_valid_i   = 1'b1;
    mul_product_i = 64'hDEAD_BEEF;
    @(negedge clk_i);
    mul_valid_i = 1'b0;
    checkOutput("stray.done",    64'(done_o),      64'd0);
    checkOutput("stray.start",   64'(mul_start_o), 64'd0);
    checkOutput("stray.product", product_o,        64'd0);
    @(negedge clk_i);
    checkOutput("stray.done2",   64'(done_o),      64'd0);

    setOps(0, 32'd7, 32'd6, 1'b0);
    applyStimulus("single", 2'b01, 0, 32, 1'b0, 64'd42);

    setOps(0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    applyStimulus("signed", 2'b01, 0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);

    // Reset in WAIT with ptr=1: all outputs clear and no done follows.
    setOps(1, 32'h0000_0100, 32'h0000_0200, 1'b0);
    req_i = 2'b10;
    #1;
    checkOutput("midrst.gnt", 64'(gnt_o), 64'd2);
    @(negedge clk_i);
    req_i = 2'b00;
    checkOutput("midrst.start", 64'(mul_start_o), 64'd1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkAllZero("midrst");
    rst_i = 1'b0;
    mul_valid_i   = 1'b1;
    mul_product_i = 64'h0002_0000;
    @(negedge clk_i);
    mul_valid_i = 1'b0;
    checkOutput("midrst.nodone",  64'(done_o), 64'd0);
    @(negedge clk_i);
    checkOutput("midrst.nodone2", 64'(done_o), 64'd0);
    checkOutput("midrst.product", product_o,   64'd0);

    // Contention with both requests held: ptr restarts at 0 after reset.
    setOps(0, 32'd100, 32'd200, 1'b0);
    setOps(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("cont0", 2'b11, 0, 2, 1'b1, 64'd20000);
    applyStimulus("cont1", 2'b11, 1, 4, 1'b1, 64'hFFFF_FFFE_0000_0001);
    applyStimulus("cont2", 2'b11, 0, 1, 1'b1, 64'd20000);
    applyStimulus("cont3", 2'b11, 1, 0, 1'b0, 64'hFFFF_FFFE_0000_0001);

`ifdef MUL_SHARE_TIMEOUT_EN
    // Watchdog: 41 WAIT cycles without valid, then done with err.
    setOps(0, 32'd9, 32'd9, 1'b0);
    req_i = 2'b01;
    #1;
    checkOutput("tmo.gnt", 64'(gnt_o), 64'd1);
    @(negedge clk_i);
    req_i = 2'b00;
    checkOutput("tmo.start", 64'(mul_start_o), 64'd1);
    for (int k = 0; k < 41; k++) begin
      @(negedge clk_i);
      checkOutput("tmo.wait_done", 64'(done_o), 64'd0);
    end
    @(negedge clk_i);
    checkOutput("tmo.done",    64'(done_o), 64'd1);
    checkOutput("tmo.err",     64'(err_o),  64'd1);
    checkOutput("tmo.product", product_o,   64'd0);
    @(negedge clk_i);
    checkOutput("tmo.err_off", 64'(err_o),  64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
